// File: rtl/poly_mod_canon.sv
// Canonical reduction of a redundant polynomial: word-serial carry propagation, then
// bounded subtraction of MODULUS. Optional stats ports under POLY_MOD_CANON_STATS_EN.
module poly_mod_canon #(
  parameter int WORD_BITS       = 32,
  parameter int NUM_WORDS       = 32,
  parameter int REDUN_WORD_BITS = 1,
  parameter int I_WORD          = NUM_WORDS + 1,
  parameter int COEF_BITS       = WORD_BITS + REDUN_WORD_BITS,
  parameter logic [WORD_BITS*NUM_WORDS-1:0] MODULUS =
    {{(WORD_BITS*NUM_WORDS-8){1'b1}}, 8'h43},
  parameter int MAX_SUB         = 8
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_val,
  output logic                                o_rdy,
  input  logic [I_WORD-1:0][COEF_BITS-1:0]    i_dat,
  output logic                                o_val,
  input  logic                                i_rdy,
  output logic [I_WORD-1:0][COEF_BITS-1:0]    o_dat,
  output logic [WORD_BITS*NUM_WORDS-1:0]      o_int,
  output logic                                o_err
`ifdef POLY_MOD_CANON_STATS_EN
  ,
  output logic [$clog2(MAX_SUB+1)-1:0]        o_sub_cnt,
  output logic [$clog2(MAX_SUB+1)-1:0]        o_max_sub
`endif
);

  localparam int ACC_BITS = I_WORD*WORD_BITS + 2;
  localparam int MOD_BITS = WORD_BITS*NUM_WORDS;
  localparam int SUM_BITS = COEF_BITS + 1;
  localparam int CAR_BITS = SUM_BITS - WORD_BITS;
  localparam int IDX_W    = $clog2(I_WORD);
  localparam int CNT_W    = $clog2(MAX_SUB+1);
  localparam logic [ACC_BITS-1:0] MOD_EXT  = ACC_BITS'(MODULUS);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(I_WORD-1);
  localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(MAX_SUB);

  typedef enum logic [1:0] {IDLE, CARRY, SUB, DONE} state_t;

  state_t                          state_q, state_d;
  logic [I_WORD-1:0][COEF_BITS-1:0] buf_q, buf_d;
  logic [ACC_BITS-1:0]             acc_q, acc_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [CAR_BITS-1:0]             carry_q, carry_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            err_q, err_d;
  logic [SUM_BITS-1:0]             sum;
  logic                            acc_ge;

  assign acc_ge = (acc_q >= MOD_EXT);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      carry_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_val) state_d = CARRY;
      CARRY:   if (idx_q == IDX_LAST) state_d = SUB;
      SUB:     if (!acc_ge || cnt_q == CNT_MAX) state_d = DONE;
      DONE:    if (i_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    buf_d   = buf_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    sum     = SUM_BITS'(buf_q[idx_q]) + SUM_BITS'(carry_q);
    case (state_q)
      IDLE: begin
        if (i_val) begin
          buf_d   = i_dat;
          acc_d   = '0;
          idx_d   = '0;
          carry_d = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      CARRY: begin
        acc_d[idx_q*WORD_BITS +: WORD_BITS] = sum[WORD_BITS-1:0];
        carry_d = sum[SUM_BITS-1:WORD_BITS];
        idx_d   = idx_q + IDX_W'(1);
        // The last word's carry lands in the two guard bits above the polynomial.
        if (idx_q == IDX_LAST) acc_d[ACC_BITS-1 -: 2] = 2'(sum[SUM_BITS-1:WORD_BITS]);
      end
      SUB: begin
        if (acc_ge) begin
          if (cnt_q != CNT_MAX) begin
            acc_d = acc_q - MOD_EXT;
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    o_rdy = (state_q == IDLE);
    o_val = (state_q == DONE);
    o_err = err_q;
    o_int = acc_q[MOD_BITS-1:0];
  end

  for (genvar gi = 0; gi < I_WORD; gi++) begin : g_dat
    if (gi < I_WORD-1) begin : g_word
      assign o_dat[gi] = COEF_BITS'(acc_q[gi*WORD_BITS +: WORD_BITS]);
    end else begin : g_top
      assign o_dat[gi] = '0;
    end
  end

`ifdef POLY_MOD_CANON_STATS_EN
  logic [CNT_W-1:0] max_q, max_d;

  always_comb begin
    max_d = max_q;
    if (state_q == SUB && state_d == DONE && cnt_q > max_q) max_d = cnt_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) max_q <= '0;
    else       max_q <= max_d;
  end

  assign o_sub_cnt = cnt_q;
  assign o_max_sub = max_q;
`endif

endmodule

// File: tb/tb_poly_mod_canon.sv
// Directed-vector bench for poly_mod_canon: residue value, latency, handshake, error path
// and mid-operation reset.
`timescale 1ns/1ps
module tb_poly_mod_canon;

  localparam int W       = 32;
  localparam int IW      = 33;
  localparam int CB      = 33;
  localparam int MB      = 1024;
  localparam int VB      = 1060;
  localparam int MAX_SUB = 8;
  localparam logic [MB-1:0] MOD = {{(MB-8){1'b1}}, 8'h43};

  logic                     i_clk = 1'b0;
  logic                     i_rst = 1'b1;
  logic                     i_val = 1'b0;
  logic                     i_rdy = 1'b1;
  logic [IW-1:0][CB-1:0]    i_dat = '0;
  logic                     o_rdy;
  logic                     o_val;
  logic [IW-1:0][CB-1:0]    o_dat;
  logic [MB-1:0]            o_int;
  logic                     o_err;
`ifdef POLY_MOD_CANON_STATS_EN
  logic [3:0]               o_sub_cnt;
  logic [3:0]               o_max_sub;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [IW-1:0][CB-1:0]    p;
  logic [VB-1:0]            v;
  logic [MB-1:0]            exp_res;
  int                       exp_k;
  bit                       exp_e;

  poly_mod_canon #(.MODULUS(MOD)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_val(i_val), .o_rdy(o_rdy), .i_dat(i_dat),
    .o_val(o_val), .i_rdy(i_rdy), .o_dat(o_dat), .o_int(o_int), .o_err(o_err)
`ifdef POLY_MOD_CANON_STATS_EN
    , .o_sub_cnt(o_sub_cnt), .o_max_sub(o_max_sub)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [VB-1:0] got, input logic [VB-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got ...%0h expected ...%0h (low 200 bits)", tag, got[199:0], exp[199:0]);
    end
  endtask

  function automatic logic [IW-1:0][CB-1:0] to_poly(input logic [VB-1:0] val);
    logic [IW-1:0][CB-1:0] r;
    for (int i = 0; i < IW; i++) r[i] = CB'(val[i*W +: W]);
    return r;
  endfunction

  function automatic logic [VB-1:0] poly_val(input logic [IW-1:0][CB-1:0] q);
    logic [VB-1:0] s;
    s = '0;
    for (int i = 0; i < IW; i++) s = s + (VB'(q[i]) << (i*W));
    return s;
  endfunction

  // Arithmetic reference: repeated subtraction with the same bound as the block.
  task automatic ref_canon(input logic [VB-1:0] val, output logic [MB-1:0] res,
                           output int k, output bit err);
    logic [VB-1:0] a;
    a = val; k = 0; err = 1'b0;
    while (a >= VB'(MOD)) begin
      if (k == MAX_SUB) begin
        err = 1'b1;
        break;
      end
      a = a - VB'(MOD);
      k++;
    end
    res = a[MB-1:0];
  endtask

  task automatic run_vec(input string tag, input logic [IW-1:0][CB-1:0] q,
                         input logic [MB-1:0] e_int, input int e_k, input bit e_err);
    int cyc;
    bit seen;
    @(negedge i_clk);
    check({tag, "_rdy"}, VB'(o_rdy), VB'(1));
    i_dat = q;
    i_val = 1'b1;
    @(posedge i_clk);
    #1 i_val = 1'b0;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(posedge i_clk);
      cyc++;
      #1;
      if (o_val) seen = 1'b1;
    end
    check({tag, "_lat"}, VB'(cyc), VB'(IW + 1 + e_k));
    check({tag, "_int"}, VB'(o_int), VB'(e_int));
    check({tag, "_err"}, VB'(o_err), VB'(e_err));
    check({tag, "_dat0"}, VB'(o_dat[0]), VB'(e_int[W-1:0]));
    check({tag, "_dattop"}, VB'(o_dat[IW-1]), VB'(0));
`ifdef POLY_MOD_CANON_STATS_EN
    check({tag, "_subcnt"}, VB'(o_sub_cnt), VB'(e_k));
`endif
    $display("vec %s: cycles=%0d err=%0b int_lo=%0h", tag, cyc, o_err, o_int[63:0]);
    if (i_rdy) begin
      @(posedge i_clk);
      #1;
      check({tag, "_valdrop"}, VB'(o_val), VB'(0));
      check({tag, "_rdyback"}, VB'(o_rdy), VB'(1));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_rdy", VB'(o_rdy), VB'(1));
    check("rst_val", VB'(o_val), VB'(0));
    check("rst_err", VB'(o_err), VB'(0));
    check("rst_int", VB'(o_int), VB'(0));
    check("rst_dat", VB'(o_dat), VB'(0));
    @(negedge i_clk);
    i_rst = 1'b0;

    // coef0 = 2
    p = '0;
    p[0] = CB'(2);
    run_vec("two", p, MB'(2), 0, 1'b0);

    // exactly MODULUS -> 0 after one subtraction
    run_vec("mod", to_poly(VB'(MOD)), MB'(0), 1, 1'b0);

    // 3*MODULUS+5, redundant: coef0 bit 32 set, coef1 reduced by 1
    p = to_poly(VB'(MOD) * 3 + VB'(5));
    p[0] = p[0] | (CB'(1) << W);
    p[1] = p[1] - CB'(1);
    run_vec("m3p5", p, MB'(5), 3, 1'b0);
`ifdef POLY_MOD_CANON_STATS_EN
    check("max_after_m3p5", VB'(o_max_sub), VB'(3));
`endif

    // backpressure
    i_rdy = 1'b0;
    run_vec("bp", to_poly(VB'(9)), MB'(9), 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      i_val = 1'b1;
      i_dat = to_poly(VB'(123));
      @(posedge i_clk);
      #1;
      check("bp_val", VB'(o_val), VB'(1));
      check("bp_int", VB'(o_int), VB'(9));
      check("bp_rdy", VB'(o_rdy), VB'(0));
    end
    @(negedge i_clk);
    i_val = 1'b0;
    i_rdy = 1'b1;
    @(posedge i_clk);
    #1;
    check("bp_valdrop", VB'(o_val), VB'(0));
    check("bp_rdyback", VB'(o_rdy), VB'(1));

    // all-zero input
    run_vec("zero", '0, MB'(0), 0, 1'b0);

    // ripple: every low coefficient 0x1_FFFF_FFFF, carries run through all words
    p = '0;
    for (int i = 0; i < IW-1; i++) p[i] = {1'b1, {W{1'b1}}};
    v = poly_val(p);
    ref_canon(v, exp_res, exp_k, exp_e);
    run_vec("ripple", p, exp_res, exp_k, exp_e);

    // 20*MODULUS exceeds the subtraction bound: 12*MODULUS truncated = 2^1024 - 2268
    run_vec("err20", to_poly(VB'(MOD) * 20), MB'(0) - MB'(2268), MAX_SUB, 1'b1);
`ifdef POLY_MOD_CANON_STATS_EN
    check("max_after_err", VB'(o_max_sub), VB'(MAX_SUB));
`endif

    // reset while CARRY is on index 10
    @(negedge i_clk);
    i_dat = to_poly(VB'(MOD) - VB'(1));
    i_val = 1'b1;
    @(posedge i_clk);
    #1 i_val = 1'b0;
    repeat (10) @(posedge i_clk);
    #1 i_rst = 1'b1;
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    check("midrst_val", VB'(o_val), VB'(0));
    check("midrst_rdy", VB'(o_rdy), VB'(1));
    check("midrst_int", VB'(o_int), VB'(0));
`ifdef POLY_MOD_CANON_STATS_EN
    check("midrst_max", VB'(o_max_sub), VB'(0));
`endif
    run_vec("after_rst", to_poly(VB'(7)), MB'(7), 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/poly_mod_canon.md
Name: poly_mod_canon

Overview:
Downstream stage of poly_mod_sq_wrapper. Takes the redundant polynomial result (I_WORD coefficients of COEF_BITS each, value = sum a[i]*2^(i*WORD_BITS), possibly several moduli above the residue) and produces the canonical residue in [0, MODULUS).
- Output is presented both as a flat integer and as a normalised polynomial (every coefficient < 2^WORD_BITS, top coefficient 0), so it can be looped back into the squarer or handed to host logic.
- Word-serial carry propagation, then bounded repeated subtraction of MODULUS.

Parameters:
- WORD_BITS, 32, bits per polynomial word.
- NUM_WORDS, 32, words in the modulus.
- REDUN_WORD_BITS, 1, redundant bits per coefficient.
- I_WORD, NUM_WORDS+1, coefficients on the input.
- COEF_BITS, WORD_BITS+REDUN_WORD_BITS, coefficient width.
- MODULUS, 1024-bit constant, modulus, WORD_BITS*NUM_WORDS wide.
- MAX_SUB, 8, maximum subtractions before flagging an error.
- ACC_BITS, I_WORD*WORD_BITS+2, internal accumulator width (derived, not overridden).

Ports:
- i_clk, input, 1, clock.
- i_rst, input, 1, synchronous active-high reset.
- i_val, input, 1, input valid.
- o_rdy, output, 1, block ready to accept input.
- i_dat, input, [I_WORD-1:0][COEF_BITS-1:0], redundant polynomial.
- o_val, output, 1, result valid.
- i_rdy, input, 1, downstream ready.
- o_dat, output, [I_WORD-1:0][COEF_BITS-1:0], normalised polynomial of the residue.
- o_int, output, WORD_BITS*NUM_WORDS, residue as integer.
- o_err, output, 1, residue not reached within MAX_SUB subtractions; qualified by o_val.

Behaviour:
- Clock and reset: one clock i_clk; reset i_rst is synchronous and active-high.
- Reset values: state IDLE, o_rdy=1, o_val=0, o_err=0, o_dat=0, o_int=0; internal counters and accumulator cleared.
- States: IDLE, CARRY, SUB, DONE.
- IDLE:
  - o_rdy=1.
  - On i_val&&o_rdy, register i_dat into the coefficient buffer, clear accumulator, word index and sub count, then go to CARRY. This edge is the accept edge, edge 0.
- CARRY: one coefficient per cycle, index k=0..I_WORD-1.
  - s = buf[k] + carry, evaluated (COEF_BITS+1) bits wide.
  - acc word k <= s[WORD_BITS-1:0]; carry <= s>>WORD_BITS (at most 2 bits).
  - After k=I_WORD-1, the final carry is written into acc[ACC_BITS-1:I_WORD*WORD_BITS] and the state goes to SUB.
  - CARRY lasts exactly I_WORD cycles.
- SUB: each cycle compare acc >= MODULUS, zero-extended to ACC_BITS.
  - If true and sub_cnt < MAX_SUB: acc <= acc - MODULUS, sub_cnt++.
  - If false: go to DONE with o_err=0.
  - If true and sub_cnt == MAX_SUB: go to DONE with o_err=1; acc is passed through unreduced, truncated to the output width.
- DONE:
  - o_val=1; o_int = acc[WORD_BITS*NUM_WORDS-1:0].
  - o_dat[i] = acc word i zero-extended to COEF_BITS; o_dat[I_WORD-1]=0.
  - Outputs are held stable until i_rdy. On o_val&&i_rdy, go to IDLE and drop o_val the next cycle.
- Latency: with k subtractions needed (k<=MAX_SUB), o_val is high after edge I_WORD+k+1 relative to the accept edge.
  - Example: I_WORD=33, k=0 gives o_val after edge 34.
- Handshake rules:
  - o_rdy is 1 only in IDLE.
  - i_val is ignored in every other state; there is no queuing.
  - o_val never deasserts without i_rdy, except on reset.
  - Back-to-back operation: the next accept is possible the cycle after the output handshake, i.e. there is one IDLE cycle minimum.
- Boundary conditions:
  - acc == MODULUS exactly subtracts to 0.
  - An all-zero input gives 0 with k=0.
  - Coefficients carrying bit WORD_BITS set must carry correctly across all words, including into the top accumulator bits.
- Reset mid-operation: any state returns to IDLE on the next edge, o_val=0, partial result discarded.

Optional Feature:
Macro: POLY_MOD_CANON_STATS_EN.
- Defined: adds two output ports.
  - o_sub_cnt, $clog2(MAX_SUB+1) bits: sub_cnt of the current result, valid with o_val.
  - o_max_sub, same width: sticky maximum of sub_cnt over all results since reset; reset value 0.
- Not defined: neither port exists and no counter logic is synthesised. Core behaviour is identical in both builds.

Test Plan:
- Input poly coef0=2, others 0, i_rdy=1 -> o_int=2, o_dat[0]=2, o_err=0, o_val after edge 34 (k=0).
- Input = MODULUS as poly (32-bit words, top coef 0) -> o_int=0, k=1, o_val after edge 35.
- Input 3*MODULUS+5, encoded redundantly with coef0 bit 32 set and coef1 reduced by 1 -> o_int=5, k=3; with POLY_MOD_CANON_STATS_EN, o_sub_cnt=3 and o_max_sub=3.
- Backpressure: result ready but i_rdy=0 for 10 cycles -> o_val and o_int held constant, o_rdy=0, i_val pulses ignored; i_rdy=1 -> o_val low the next cycle, o_rdy=1.
- Input 20*MODULUS with MAX_SUB=8 -> o_val with o_err=1 after edge 33+8+1=42.
- Reset asserted for 1 cycle at CARRY index 10 -> next cycle o_val=0, o_rdy=1; a subsequent input of 7 yields o_int=7.
